demux_1x3_reg: RTL and testbench

DEMUX_1X3_REG -- requirements
Module: demux_1x3_reg

---
 rtl/demux_1x3_reg_if.sv | 40 ++++
 rtl/demux_1x3_reg.sv | 113 +++++++++++
 tb/tb_demux_1x3_reg.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1x3_reg_if.sv
// Upstream word/select/handshake and the three downstream channel ports of demux_1x3_reg.
// The demux itself connects through the slave modport; the producer/consumer side uses master.
interface demux_1x3_reg_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data_in;
  logic [1:0]            sel_1x3_in;
  logic                  valid_in;
  logic                  ready_out;

  logic [DATA_WIDTH-1:0] out_00;
  logic [DATA_WIDTH-1:0] out_01;
  logic [DATA_WIDTH-1:0] out_10;
  logic                  valid_00_out;
  logic                  valid_01_out;
  logic                  valid_10_out;
  logic                  ready_00_in;
  logic                  ready_01_in;
  logic                  ready_10_in;

  logic [15:0]           xfer_count_out;

  modport slave (
    input  data_in, sel_1x3_in, valid_in,
    input  ready_00_in, ready_01_in, ready_10_in,
    output ready_out,
    output out_00, out_01, out_10,
    output valid_00_out, valid_01_out, valid_10_out,
    output xfer_count_out
  );

  modport master (
    output data_in, sel_1x3_in, valid_in,
    output ready_00_in, ready_01_in, ready_10_in,
    input  ready_out,
    input  out_00, out_01, out_10,
    input  valid_00_out, valid_01_out, valid_10_out,
    input  xfer_count_out
  );
endinterface

// File: rtl/demux_1x3_reg.sv
// Registered 1-to-3 demux with one holding register per output channel and
// valid/ready handshakes on both sides; counts accepted words.
module demux_1x3_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  demux_1x3_reg_if.slave  bus
);

  localparam int NUM_CH = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e             state_q [NUM_CH];
  ch_state_e             state_d [NUM_CH];
  logic [DATA_WIDTH-1:0] data_q  [NUM_CH];

  logic [NUM_CH-1:0] tgt_hot;
  logic [NUM_CH-1:0] full_vec;
  logic [NUM_CH-1:0] drain_rdy;
  logic [NUM_CH-1:0] load;
  logic              ready;
  logic              accept;
  logic [15:0]       count_q;

  // Channel index order throughout: bit 0 = ch00, bit 1 = ch01, bit 2 = ch10.
  assign drain_rdy = {bus.ready_10_in, bus.ready_01_in, bus.ready_00_in};

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    tgt_hot = 3'b100;
    case (bus.sel_1x3_in)
      2'b00:   tgt_hot = 3'b001;
      2'b01:   tgt_hot = 3'b010;
      default: tgt_hot = 3'b100;
    endcase
  end

  always_comb begin
    full_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      full_vec[i] = (state_q[i] == FULL);
    end
  end

  // A full target can still take a word when its consumer drains it this same
  // cycle, which keeps back-to-back traffic bubble-free.
  assign ready  = |(tgt_hot & (~full_vec | drain_rdy));
  assign accept = bus.valid_in & ready;
  assign load   = tgt_hot & {NUM_CH{accept}};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        EMPTY: if (load[i]) state_d[i] = FULL;
        FULL:  if (!load[i] && drain_rdy[i]) state_d[i] = EMPTY;
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= EMPTY;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: the holding registers are reset on purpose: the channel outputs
    // must read zero while reset is asserted, not just be flagged invalid.
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) data_q[i] <= bus.data_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign bus.ready_out      = ready;
  assign bus.out_00         = data_q[0];
  assign bus.out_01         = data_q[1];
  assign bus.out_10         = data_q[2];
  assign bus.valid_00_out   = full_vec[0];
  assign bus.valid_01_out   = full_vec[1];
  assign bus.valid_10_out   = full_vec[2];
  assign bus.xfer_count_out = count_q;

endmodule

// File: tb/tb_demux_1x3_reg.sv
// Directed bench for demux_1x3_reg: expected words are queued per channel at
// issue time and a negedge monitor pops/compares on every channel delivery.
module tb_demux_1x3_reg;

  localparam int BUDGET = 20;

  logic clk;
  logic rst_n;

  demux_1x3_reg_if #(.DATA_WIDTH(16)) bus ();

  demux_1x3_reg #(.DATA_WIDTH(16)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];
  logic [15:0] exp_count = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int chan_of(input logic [1:0] s);
    if (s == 2'b00) return 0;
    if (s == 2'b01) return 1;
    return 2;
  endfunction

  task automatic push_exp(input int ch, input logic [15:0] d);
    case (ch)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic flush_exp();
    q0.delete();
    q1.delete();
    q2.delete();
    exp_count = 16'd0;
  endtask

  // Called at posedge+1; offers one word and returns at posedge+1 after the accept edge.
  task automatic offer(input logic [15:0] d, input logic [1:0] s, output int waited);
    logic got;
    got = 1'b0;
    waited = 0;
    bus.data_in    = d;
    bus.sel_1x3_in = s;
    bus.valid_in   = 1'b1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (bus.ready_out) begin
        got = 1'b1;
        break;
      end
      waited++;
    end
    if (got) begin
      push_exp(chan_of(s), d);
      exp_count = exp_count + 16'd1;
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL offer_timeout: ready_out stayed 0 for %0d cycles, expected 1 (data %h sel %b)", BUDGET, d, s);
    end
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic deliver(input int ch, input logic [15:0] act);
    logic [15:0] e;
    n_tests++;
    case (ch)
      0: begin if (q0.size() == 0) e = 'x; else e = q0.pop_front(); end
      1: begin if (q1.size() == 0) e = 'x; else e = q1.pop_front(); end
      default: begin if (q2.size() == 0) e = 'x; else e = q2.pop_front(); end
    endcase
    if (e === 'x) begin
      n_fail++;
      $display("FAIL deliver_ch%0d: got unexpected word %h, expected no delivery", ch, act);
    end else if (act !== e) begin
      n_fail++;
      $display("FAIL deliver_ch%0d: got %h, expected %h (t=%0t)", ch, act, e, $time);
    end
  endtask

  // Monitor: a delivery happens on the edge following a negedge where valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.valid_00_out && bus.ready_00_in) deliver(0, bus.out_00);
        if (bus.valid_01_out && bus.ready_01_in) deliver(1, bus.out_01);
        if (bus.valid_10_out && bus.ready_10_in) deliver(2, bus.out_10);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    rst_n = 1'b0;
    bus.data_in = '0;
    bus.sel_1x3_in = 2'b00;
    bus.valid_in = 1'b0;
    bus.ready_00_in = 1'b0;
    bus.ready_01_in = 1'b0;
    bus.ready_10_in = 1'b0;

    // Reset state, and an offer during reset must be ignored.
    #2;
    check("rst_valids", {bus.valid_00_out, bus.valid_01_out, bus.valid_10_out}, 3'b000);
    check("rst_outs_zero", {bus.out_00, bus.out_01, bus.out_10}, 48'h0);
    check("rst_count", bus.xfer_count_out, 16'h0000);
    check("rst_ready_out", bus.ready_out, 1'b1);
    bus.valid_in = 1'b1;
    bus.data_in = 16'hDEAD;
    @(posedge clk); #1;
    check("rst_accept_ignored", {bus.valid_00_out, bus.xfer_count_out}, 17'h0);
    bus.valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic accept into ch00, consumer stalled.
    offer(16'h1234, 2'b00, w);
    @(negedge clk);
    check("s1_valid_00", bus.valid_00_out, 1'b1);
    check("s1_out_00", bus.out_00, 16'h1234);
    check("s1_other_valids", {bus.valid_01_out, bus.valid_10_out}, 2'b00);
    check("s1_count", bus.xfer_count_out, 16'd1);

    // Offer to the stalled ch00: blocked for 5 cycles, then unblocked by drain.
    @(posedge clk); #1;
    bus.valid_in = 1'b1;
    bus.data_in = 16'h5678;
    bus.sel_1x3_in = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s2_ready_blocked", bus.ready_out, 1'b0);
      check("s2_out_00_held", bus.out_00, 16'h1234);
    end
    @(posedge clk); #1;
    bus.ready_00_in = 1'b1;
    @(negedge clk);
    check("s2_ready_same_cycle", bus.ready_out, 1'b1);
    push_exp(0, 16'h5678);
    exp_count = exp_count + 16'd1;
    @(posedge clk); #1;
    bus.ready_00_in = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check("s2_valid_00_no_bubble", bus.valid_00_out, 1'b1);
    check("s2_out_00_new", bus.out_00, 16'h5678);
    check("s2_count", bus.xfer_count_out, exp_count);

    // sel=11 routes to ch10.
    @(posedge clk); #1;
    offer(16'hBEEF, 2'b11, w);
    @(negedge clk);
    check("s3_out_10", bus.out_10, 16'hBEEF);
    check("s3_valid_10", bus.valid_10_out, 1'b1);
    check("s3_ch00_untouched", {bus.valid_00_out, bus.out_00}, {1'b1, 16'h5678});
    check("s3_ch01_untouched", bus.valid_01_out, 1'b0);

    // Drain ch10 alone; it goes empty and keeps its last value on the output.
    @(posedge clk); #1;
    bus.ready_10_in = 1'b1;
    @(posedge clk); #1;
    bus.ready_10_in = 1'b0;
    @(negedge clk);
    check("drain_10_empty", bus.valid_10_out, 1'b0);
    check("drain_10_retain", bus.out_10, 16'hBEEF);

    // Stalled ch01 must not block an accept to ch10.
    @(posedge clk); #1;
    offer(16'h0101, 2'b01, w);
    offer(16'h00AA, 2'b10, w);
    check("s4_accept_immediate", w, 0);
    @(negedge clk);
    check("s4_valid_10", {bus.valid_10_out, bus.out_10}, {1'b1, 16'h00AA});
    check("s4_ch01_held", {bus.valid_01_out, bus.out_01}, {1'b1, 16'h0101});
    check("s4_count", bus.xfer_count_out, 16'd5);

    // Concurrent drain of all three channels.
    @(posedge clk); #1;
    {bus.ready_00_in, bus.ready_01_in, bus.ready_10_in} = 3'b111;
    @(posedge clk); #1;
    {bus.ready_00_in, bus.ready_01_in, bus.ready_10_in} = 3'b000;
    @(negedge clk);
    check("concurrent_drain", {bus.valid_00_out, bus.valid_01_out, bus.valid_10_out}, 3'b000);

    // ready while empty is ignored.
    @(posedge clk); #1;
    bus.ready_01_in = 1'b1;
    @(posedge clk); #1;
    bus.ready_01_in = 1'b0;
    @(negedge clk);
    check("ready_while_empty", {bus.valid_01_out, bus.xfer_count_out}, {1'b0, 16'd5});

    // Count wrap: fresh reset, 65535 accepts, then one more.
    @(posedge clk); #1;
    rst_n = 1'b0;
    flush_exp();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    {bus.ready_00_in, bus.ready_01_in, bus.ready_10_in} = 3'b111;
    for (int i = 0; i < 65535; i++) begin
      logic [15:0] d;
      logic [1:0]  s;
      d = i[15:0] ^ 16'hA5A5;
      s = (i % 3 == 0) ? 2'b00 : (i % 3 == 1) ? 2'b01 : 2'b11;
      offer(d, s, w);
    end
    @(negedge clk);
    check("wrap_pre_ffff", bus.xfer_count_out, 16'hFFFF);
    @(posedge clk); #1;
    offer(16'h7777, 2'b01, w);
    @(negedge clk);
    check("wrap_to_zero", bus.xfer_count_out, 16'h0000);
    @(posedge clk); #1;
    {bus.ready_00_in, bus.ready_01_in, bus.ready_10_in} = 3'b000;

    // Fill all three channels, then reset asynchronously between edges.
    offer(16'h1111, 2'b00, w);
    offer(16'h2222, 2'b01, w);
    offer(16'h3333, 2'b10, w);
    @(negedge clk);
    check("all_full", {bus.valid_00_out, bus.valid_01_out, bus.valid_10_out}, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valids", {bus.valid_00_out, bus.valid_01_out, bus.valid_10_out}, 3'b000);
    check("async_rst_outs", {bus.out_00, bus.out_01, bus.out_10}, 48'h0);
    check("async_rst_count", bus.xfer_count_out, 16'h0000);
    check("async_rst_ready", bus.ready_out, 1'b1);
    flush_exp();
    bus.valid_in = 1'b1;
    bus.sel_1x3_in = 2'b01;
    bus.data_in = 16'h9999;
    @(posedge clk); #1;
    check("rst_accept_ignored2", {bus.valid_01_out, bus.xfer_count_out}, 17'h0);
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", {bus.valid_00_out, bus.valid_01_out, bus.valid_10_out}, 3'b000);
    end

    // First accept lands on the first edge after reset release.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    offer(16'h4444, 2'b10, w);
    check("first_edge_accept", w, 0);
    @(negedge clk);
    check("first_accept_out", {bus.valid_10_out, bus.out_10}, {1'b1, 16'h4444});
    check("first_accept_count", bus.xfer_count_out, 16'd1);

    // Final drain; every expected word must have been delivered.
    @(posedge clk); #1;
    {bus.ready_00_in, bus.ready_01_in, bus.ready_10_in} = 3'b111;
    @(posedge clk); #1;
    {bus.ready_00_in, bus.ready_01_in, bus.ready_10_in} = 3'b000;
    @(negedge clk);
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);
    check("end_valids", {bus.valid_00_out, bus.valid_01_out, bus.valid_10_out}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
